// File: rtl/bcd_bin_pkg.sv
// ----------------------------------------------------------------------------
// bcd_bin_pkg
// Shared definitions for the BCD/binary converter peripheral:
//   - register address map (low 5 bits of the J1 I/O address)
//   - conversion mode encodings
//   - converter FSM state encoding
//   - pow10() constant function used for the binary->BCD overflow limit
// ----------------------------------------------------------------------------
package bcd_bin_pkg;

   localparam logic [4:0] ADDR_OPERAND = 5'h04;
   localparam logic [4:0] ADDR_MODE    = 5'h08;
   localparam logic [4:0] ADDR_CTRL    = 5'h0C;
   localparam logic [4:0] ADDR_RESULT  = 5'h10;
   localparam logic [4:0] ADDR_STATUS  = 5'h14;

   localparam logic MODE_BCD2BIN = 1'b0;
   localparam logic MODE_BIN2BCD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } conv_state_e;

   // 10^digits as a 64-bit constant; digits is at most 8 so this never wraps.
   function automatic logic [63:0] pow10(input int digits);
      logic [63:0] acc;
      acc = 64'd1;
      for (int i = 0; i < digits; i++) begin
         acc = acc * 64'd10;
      end
      return acc;
   endfunction

endpackage

// File: rtl/bcd_bin_core.sv
// ----------------------------------------------------------------------------
// bcd_bin_core
// Iterative BCD<->binary converter, one bit per clock.
//   mode 0: reverse double-dabble, packed BCD -> binary
//   mode 1: double-dabble, binary -> packed BCD
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle start pulse, honoured only in IDLE
//   mode       : conversion direction, sampled in CHECK
//   operand    : value to convert, sampled in CHECK
//   busy       : conversion shifting in progress
//   done       : sticky completion flag (cleared by an accepted start)
//   error      : sticky invalid-digit / overflow flag
//   result     : last converted value (0 after an error)
// ----------------------------------------------------------------------------
module bcd_bin_core
   import bcd_bin_pkg::*;
#(
   parameter  int DIGITS = 5,
   parameter  int BIN_W  = 17,
   localparam int BCD_W  = 4 * DIGITS,
   localparam int RES_W  = (BCD_W > BIN_W) ? BCD_W : BIN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [RES_W-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [RES_W-1:0] result
);

   localparam int          SR_W  = BCD_W + BIN_W;
   localparam int          CNT_W = $clog2(BIN_W + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS);

   conv_state_e      state_q, state_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [RES_W-1:0] result_q, result_d;

   logic             invalid_s;
   logic [SR_W-1:0]  sr_right_s;
   logic [SR_W-1:0]  sr_step_s;
   logic [BCD_W-1:0] bcd_adj_s;

   // Reverse dabble correction: digits that picked up a halved 10 (>= 8) lose 3.
   function automatic logic [BCD_W-1:0] digits_sub3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd8) begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Forward dabble correction: digits >= 5 get +3 so the next doubling carries.
   function automatic logic [BCD_W-1:0] digits_add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction

   // Operand validation and one shift/correct step of the datapath.
   always_comb begin
      if (mode == MODE_BCD2BIN) begin
         invalid_s = has_bad_digit(operand[BCD_W-1:0]);
      end else begin
         invalid_s = (64'(operand[BIN_W-1:0]) >= LIMIT);
      end

      sr_right_s = sr_q >> 1;
      bcd_adj_s  = digits_add3(sr_q[SR_W-1:BIN_W]);
      if (mode_q == MODE_BCD2BIN) begin
         sr_step_s = {digits_sub3(sr_right_s[SR_W-1:BIN_W]), sr_right_s[BIN_W-1:0]};
      end else begin
         sr_step_s = {bcd_adj_s, sr_q[BIN_W-1:0]} << 1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (invalid_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Counter reaches 0 on this edge: the last iteration is being applied.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and flag next-state values for each FSM state.
   always_comb begin
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      busy_d   = busy_q;
      done_d   = done_q;
      error_d  = error_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d  = 1'b0;
               error_d = 1'b0;
            end else begin
               done_d  = done_q;
               error_d = error_q;
            end
         end
         ST_CHECK: begin
            mode_d = mode;
            if (invalid_s) begin
               error_d  = 1'b1;
               done_d   = 1'b1;
               result_d = '0;
            end else begin
               busy_d = 1'b1;
               cnt_d  = CNT_W'(BIN_W);
               if (mode == MODE_BCD2BIN) begin
                  sr_d = {operand[BCD_W-1:0], {BIN_W{1'b0}}};
               end else begin
                  sr_d = {{BCD_W{1'b0}}, operand[BIN_W-1:0]};
               end
            end
         end
         ST_RUN: begin
            sr_d  = sr_step_s;
            cnt_d = cnt_q - CNT_W'(1);
         end
         ST_FINISH: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (mode_q == MODE_BCD2BIN) begin
               result_d = RES_W'(sr_q[BIN_W-1:0]);
            end else begin
               result_d = RES_W'(sr_q[SR_W-1:BIN_W]);
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q     <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         result_q <= '0;
      end else begin
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign error  = error_q;
   assign result = result_q;

endmodule

// File: rtl/peripheral_bcd_bin_conv.sv
// ----------------------------------------------------------------------------
// peripheral_bcd_bin_conv
// Memory-mapped BCD<->binary converter on the J1 I/O bus.
// Registers: 04 OPERAND (RW), 08 MODE (RW), 0C CTRL (W, bit0 start),
//            10 RESULT (R), 14 STATUS (R, {error, busy, done}).
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   d_in  : write data
//   cs    : peripheral select
//   addr  : register address
//   rd    : read strobe
//   wr    : write strobe
//   d_out : registered read data (holds when not reading)
// ----------------------------------------------------------------------------
module peripheral_bcd_bin_conv
   import bcd_bin_pkg::*;
#(
   parameter int DIGITS = 5,
   parameter int BIN_W  = 17,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d_in,
   input  logic              cs,
   input  logic [4:0]        addr,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] d_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int RES_W = (BCD_W > BIN_W) ? BCD_W : BIN_W;

   logic [RES_W-1:0]  operand_q, operand_d;
   logic              mode_q, mode_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;

   logic              wr_en_s;
   logic              rd_en_s;
   logic              start_s;
   logic [RES_W-1:0]  operand_wr_s;
   logic [DATA_W-1:0] rd_data_s;
   logic              core_busy_s;
   logic              core_done_s;
   logic              core_error_s;
   logic [RES_W-1:0]  core_result_s;
   logic              d_in_unused_s;

   assign wr_en_s       = cs && wr;
   assign rd_en_s       = cs && rd;
   // Start is a pulse straight into the core so the FSM leaves IDLE on the write edge.
   assign start_s       = wr_en_s && (addr == ADDR_CTRL) && d_in[0];
   assign d_in_unused_s = ^d_in;

   // OPERAND width follows the mode in force when it is written.
   always_comb begin
      if (mode_q == MODE_BIN2BCD) begin
         operand_wr_s = RES_W'(d_in[BIN_W-1:0]);
      end else begin
         operand_wr_s = RES_W'(d_in[BCD_W-1:0]);
      end
   end

   // Register write decode; OPERAND and MODE are frozen while converting.
   always_comb begin
      operand_d = operand_q;
      mode_d    = mode_q;
      if (wr_en_s && !core_busy_s) begin
         case (addr)
            ADDR_OPERAND: operand_d = operand_wr_s;
            ADDR_MODE:    mode_d    = d_in[0];
            default: begin
               operand_d = operand_q;
               mode_d    = mode_q;
            end
         endcase
      end else begin
         operand_d = operand_q;
         mode_d    = mode_q;
      end
   end

   // Read mux, all values zero-extended to the bus width.
   always_comb begin
      case (addr)
         ADDR_OPERAND: rd_data_s = DATA_W'(operand_q);
         ADDR_MODE:    rd_data_s = DATA_W'(mode_q);
         ADDR_CTRL:    rd_data_s = '0;
         ADDR_RESULT:  rd_data_s = DATA_W'(core_result_s);
         ADDR_STATUS:  rd_data_s = DATA_W'({core_error_s, core_busy_s, core_done_s});
         default:      rd_data_s = '0;
      endcase
      if (rd_en_s) begin
         d_out_d = rd_data_s;
      end else begin
         d_out_d = d_out_q;
      end
   end

   // Bus-visible registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         operand_q <= '0;
         mode_q    <= 1'b0;
         d_out_q   <= '0;
      end else begin
         operand_q <= operand_d;
         mode_q    <= mode_d;
         d_out_q   <= d_out_d;
      end
   end

   assign d_out = d_out_q;

   bcd_bin_core #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .start   (start_s),
      .mode    (mode_q),
      .operand (operand_q),
      .busy    (core_busy_s),
      .done    (core_done_s),
      .error   (core_error_s),
      .result  (core_result_s)
   );

endmodule

// File: tb/tb_peripheral_bcd_bin_conv.sv
// ----------------------------------------------------------------------------
// tb_peripheral_bcd_bin_conv
// Self-checking bench: directed cases plus randomized conversions compared
// against an arithmetic reference model (decimal digit sums / repeated %10).
// ----------------------------------------------------------------------------
module tb_peripheral_bcd_bin_conv;

   localparam int DIGITS = 5;
   localparam int BIN_W  = 17;
   localparam int DATA_W = 32;

   localparam logic [4:0] A_OPERAND = 5'h04;
   localparam logic [4:0] A_MODE    = 5'h08;
   localparam logic [4:0] A_CTRL    = 5'h0C;
   localparam logic [4:0] A_RESULT  = 5'h10;
   localparam logic [4:0] A_STATUS  = 5'h14;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] d_in;
   logic              cs;
   logic [4:0]        addr;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] d_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   peripheral_bcd_bin_conv #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Bus tasks are entered at a falling edge; the access happens on the next rising edge.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; addr = 5'h00; d_in = 32'h0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0; addr = 5'h00;
      d = d_out;
   endtask

   // Reference model: plain decimal arithmetic.
   task automatic model(input bit m, input logic [31:0] op, output logic [31:0] res, output bit err);
      longint limit, val, v;
      limit = 1;
      for (int i = 0; i < DIGITS; i++) limit = limit * 10;
      err = 1'b0;
      res = 32'h0;
      if (m == 1'b0) begin
         val = 0;
         for (int i = DIGITS - 1; i >= 0; i--) begin
            v = longint'((op >> (4 * i)) & 32'hF);
            if (v > 9) err = 1'b1;
            val = val * 10 + v;
         end
         res = err ? 32'h0 : 32'(val);
      end else begin
         if (longint'(op) >= limit) begin
            err = 1'b1;
         end else begin
            v = longint'(op);
            for (int i = 0; i < DIGITS; i++) begin
               res = res | (32'(v % 10) << (4 * i));
               v = v / 10;
            end
         end
      end
   endtask

   // Polls STATUS once per cycle; `already` is the number of edges used since the start edge.
   task automatic wait_done(input string tag, input bit exp_err, input int already);
      logic [31:0] st;
      logic [31:0] prev;
      int k;
      k = already;
      prev = 32'h0;
      st = 32'h0;
      for (int n = 0; n < 200; n++) begin
         bus_read(A_STATUS, st);
         k++;
         if (st[0]) break;
         prev = st;
      end
      check_val({tag, "/latency"}, 32'(k), exp_err ? 32'd2 : 32'(BIN_W + 3));
      check_val({tag, "/pre_done_status"}, prev, exp_err ? 32'h0 : 32'h2);
      check_val({tag, "/status"}, st, exp_err ? 32'h5 : 32'h1);
   endtask

   task automatic do_conv(input string tag, input bit m, input logic [31:0] opword,
                          input logic [31:0] exp_res, input bit exp_err);
      logic [31:0] r;
      bus_write(A_MODE, {31'h0, m});
      bus_write(A_OPERAND, opword);
      bus_write(A_CTRL, 32'h1);
      wait_done(tag, exp_err, 0);
      bus_read(A_RESULT, r);
      check_val({tag, "/result"}, r, exp_res);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] raw;
      logic [31:0] op;
      logic [31:0] exp_res;
      bit          exp_err;
      bit          m;

      reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h00; d_in = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check_val("reset/d_out", d_out, 32'h0);
      bus_read(A_STATUS, r);  check_val("reset/status", r, 32'h0);
      bus_read(A_RESULT, r);  check_val("reset/result", r, 32'h0);
      bus_read(A_OPERAND, r); check_val("reset/operand", r, 32'h0);
      bus_read(A_MODE, r);    check_val("reset/mode", r, 32'h0);
      bus_write(5'h1C, 32'hFFFF_FFFF);
      bus_read(5'h1C, r);     check_val("unmapped/read", r, 32'h0);
      bus_read(A_CTRL, r);    check_val("ctrl/read", r, 32'h0);

      // Directed cases with hand-derived expectations
      do_conv("bcd_99999", 1'b0, 32'h0009_9999, 32'h0001_869F, 1'b0);
      do_conv("bin_12345", 1'b1, 32'h0000_3039, 32'h0001_2345, 1'b0);
      do_conv("bad_digit", 1'b0, 32'h0001_A000, 32'h0, 1'b1);
      do_conv("overflow",  1'b1, 32'h0001_86A0, 32'h0, 1'b1);
      do_conv("bin_99999", 1'b1, 32'h0001_869F, 32'h0009_9999, 1'b0);
      do_conv("bcd_zero",  1'b0, 32'h0000_0000, 32'h0, 1'b0);
      // Upper bits of d_in are dropped for a 17-bit operand
      do_conv("bin_mask",  1'b1, 32'hFFFE_0007, 32'h0000_0007, 1'b0);

      // Writes and a second start during a conversion are ignored
      bus_write(A_MODE, 32'h0);
      bus_write(A_OPERAND, 32'h0001_2345);
      bus_write(A_CTRL, 32'h1);
      bus_read(A_STATUS, r);
      bus_read(A_STATUS, r);  check_val("busy/status", r, 32'h2);
      bus_write(A_OPERAND, 32'h0000_0001);
      bus_write(A_CTRL, 32'h1);
      bus_write(A_MODE, 32'h1);
      wait_done("busy", 1'b0, 5);
      bus_read(A_RESULT, r);  check_val("busy/result", r, 32'h0000_3039);
      bus_read(A_OPERAND, r); check_val("busy/operand", r, 32'h0001_2345);
      bus_read(A_MODE, r);    check_val("busy/mode", r, 32'h0);

      // Reset in the middle of a conversion
      bus_write(A_OPERAND, 32'h0009_9999);
      bus_write(A_CTRL, 32'h1);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_read(A_STATUS, r);  check_val("abort/status", r, 32'h0);
      bus_read(A_RESULT, r);  check_val("abort/result", r, 32'h0);
      repeat (BIN_W + 4) @(negedge clk);
      bus_read(A_STATUS, r);  check_val("abort/status_late", r, 32'h0);
      do_conv("after_abort", 1'b0, 32'h0000_0042, 32'h0000_002A, 1'b0);

      // Randomized conversions against the reference model
      for (int t = 0; t < 30; t++) begin
         m   = 1'($urandom_range(0, 1));
         raw = $urandom;
         if (m == 1'b0) begin
            for (int i = 0; i < DIGITS; i++) begin
               raw[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 5) == 0) begin
               raw[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
            end
            op = raw & 32'h000F_FFFF;
         end else begin
            op = raw & 32'h0001_FFFF;
         end
         model(m, op, exp_res, exp_err);
         do_conv($sformatf("rand%0d", t), m, raw, exp_res, exp_err);
         bus_read(A_OPERAND, r);
         check_val($sformatf("rand%0d/operand", t), r, op);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
